// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, monitor states and fault_code bits shared by the lamp monitor.
package traffic_pkg;
  localparam logic [2:0] GREEN = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] FC_INVALID = 3'b001;
  localparam logic [2:0] FC_CONFLICT = 3'b010;
  localparam logic [2:0] FC_STUCK = 3'b100;
  typedef enum logic [1:0] {RUN, CONFIRM, FAILSAFE} mon_state_e;
  function automatic logic onehot3(input logic [2:0] c);
    return (c == GREEN) || (c == YELLOW) || (c == RED);
  endfunction
endpackage

// File: rtl/tlc_blink_timer.sv
// tlc_blink_timer: half-period counter for fail-safe red flashing; phase=1 means red lit.
module tlc_blink_timer #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase
);
  logic [7:0] cnt_q, cnt_d;
  logic phase_q, phase_d;
  logic wrap;
  always_comb begin
    wrap = cnt_q == 8'(BLINK_HALF - 1);
    cnt_d = en ? (wrap ? 8'd0 : cnt_q + 8'd1) : 8'd0;
    phase_d = en ? phase_q ^ wrap : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= 8'd0;
      phase_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  assign phase = phase_q;
endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: filters invalid/conflicting/stuck controller codes and drives fail-safe flashing red.
// Stuck-pattern detection is built only when TLM_STUCK_DETECT_EN is defined.
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int FILTER_CYC = 2,
  parameter int BLINK_HALF = 4,
  parameter int STUCK_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] M1,
  input  logic [2:0] M2,
  input  logic [2:0] M3,
  input  logic [2:0] M4,
  input  logic       fault_clr,
  output logic [3:0] lamp_g,
  output logic [3:0] lamp_y,
  output logic [3:0] lamp_r,
  output logic       fault,
  output logic [2:0] fault_code
);
  mon_state_e state_q, state_d;
  logic [3:0] filt_q, filt_d;
  logic [11:0] lamp_q, lamp_d;
  logic [2:0] code_q, code_d;
  logic [11:0] pat;
  logic invalid, conflict, stuck, f, phase, leave;
  logic [2:0] cause;
  assign pat = {M1, M2, M3, M4};
  assign invalid = !(onehot3(M1) && onehot3(M2) && onehot3(M3) && onehot3(M4));
  assign conflict = (M4 != RED && (M1 != RED || M2 != RED || M3 != RED)) || (M2 != RED && M3 != RED);
  assign cause = (stuck ? FC_STUCK : 3'b000) | (conflict ? FC_CONFLICT : 3'b000) | (invalid ? FC_INVALID : 3'b000);
  assign f = |cause;
  assign leave = state_q == FAILSAFE && state_d == RUN;
`ifdef TLM_STUCK_DETECT_EN
  logic [11:0] pat_q;
  logic [8:0] stk_q, stk_now;
  always_comb begin
    stk_now = pat != pat_q ? 9'd0 : stk_q == 9'(STUCK_MAX + 1) ? stk_q : stk_q + 9'd1;
    stuck = stk_now >= 9'(STUCK_MAX);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pat_q <= {4{RED}};
      stk_q <= 9'd0;
    end else begin
      pat_q <= pat;
      stk_q <= leave ? 9'd0 : stk_now;
    end
`else
  assign stuck = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    filt_d = 4'd0;
    code_d = code_q;
    if (state_q == RUN && f) begin
      filt_d = 4'd1;
      state_d = FILTER_CYC == 1 ? FAILSAFE : CONFIRM;
    end else if (state_q == CONFIRM) begin
      filt_d = f ? filt_q + 4'd1 : 4'd0;
      state_d = !f ? RUN : (filt_q + 4'd1 == 4'(FILTER_CYC)) ? FAILSAFE : CONFIRM;
    end else if (state_q == FAILSAFE && fault_clr && !f) begin
      state_d = RUN;
    end
    code_d = (state_d == FAILSAFE && state_q != FAILSAFE) ? cause : (state_d == RUN) ? 3'b000 : code_q;
    // Lamps only ever take a clean input pattern, so CONFIRM holds the last good one.
    lamp_d = state_d == RUN ? {M4[2], M3[2], M2[2], M1[2], M4[1], M3[1], M2[1], M1[1], M4[0], M3[0], M2[0], M1[0]} : lamp_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RUN;
      filt_q <= 4'd0;
      code_q <= 3'b000;
      lamp_q <= {4'hF, 8'h00};
    end else begin
      state_q <= state_d;
      filt_q <= filt_d;
      code_q <= code_d;
      lamp_q <= lamp_d;
    end
  tlc_blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk(clk),
    .rst(rst),
    .en(state_q == FAILSAFE),
    .phase(phase)
  );
  assign fault = state_q == FAILSAFE;
  assign fault_code = code_q;
  assign lamp_g = fault ? 4'h0 : lamp_q[3:0];
  assign lamp_y = fault ? 4'h0 : lamp_q[7:4];
  assign lamp_r = fault ? {4{phase}} : lamp_q[11:8];
endmodule
